// File: rtl/exception_arbiter_pkg.sv
// Shared types for the exception arbiter: FSM encoding, default sizes and a
// priority encoder (highest set index wins).
package exception_arbiter_pkg;

  localparam int NSRC_DEF = 3;
  localparam int CW_DEF   = 2;
  localparam int PE_W     = 32;
  localparam int PE_IW    = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [PE_IW-1:0] idx;
  } pe_t;

  function automatic pe_t prio_enc(input logic [PE_W-1:0] v);
    pe_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < PE_W; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = PE_IW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/exp_edge_sync.sv
// Two-flop synchroniser for one raw exception source, followed by a
// single-cycle rising-edge pulse.
module exp_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_sync_d;

endmodule

// File: rtl/exception_arbiter.sv
// Exception arbiter: pending/mask/in-service tracking with a req/ack handshake
// toward CP0. Define EXCEPTION_ARBITER_NEST_EN to allow nested exceptions.
module exception_arbiter
  import exception_arbiter_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exp_src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_din,
  input  logic            exp_ack,
  input  logic            eret,
  output logic            exp_req,
  output logic [CW-1:0]   exp_cause,
  output logic [NSRC-1:0] in_service,
  output logic [NSRC-1:0] pending,
  output logic            exp_block,
  output logic [NSRC-1:0] overrun
);

  logic [NSRC-1:0] w_pulse;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_in_service;
  logic [NSRC-1:0] r_overrun;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_elig;
  arb_state_t      r_state;
  logic            r_exp_req;
  logic [CW-1:0]   r_exp_cause;

  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_cause_oh;
  logic [NSRC-1:0] w_ack_clr;
  logic [NSRC-1:0] w_eret_clr;
  pe_t             w_cand_pe;
  pe_t             w_cur_pe;
  logic            w_cand_ok;
  logic            w_take;
  logic            w_abort;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    exp_edge_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (exp_src[g]),
      .o_pulse (w_pulse[g])
    );
  end

  // r_elig is the evaluation-cycle snapshot; ANDing with live state drops
  // anything acked or masked since the snapshot was taken.
  assign w_eligible = r_elig & r_pending & r_mask;
  assign w_cand_pe  = prio_enc(PE_W'(w_eligible));
  assign w_cur_pe   = prio_enc(PE_W'(r_in_service));

  always_comb begin
    w_cand_ok = 1'b0;
`ifdef EXCEPTION_ARBITER_NEST_EN
    w_cand_ok = w_cand_pe.valid && (!w_cur_pe.valid || (w_cand_pe.idx > w_cur_pe.idx));
`else
    w_cand_ok = w_cand_pe.valid && !w_cur_pe.valid;
`endif
  end

  always_comb begin
    w_cause_oh = '0;
    w_eret_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_cause_oh[i] = (r_exp_cause == CW'(i));
      w_eret_clr[i] = eret && w_cur_pe.valid && (w_cur_pe.idx == PE_IW'(i));
    end
  end

  assign w_take    = (r_state == ST_REQ) && exp_ack;
  assign w_abort   = (r_state == ST_REQ) && !exp_ack && mask_we && |(w_cause_oh & ~mask_din);
  assign w_ack_clr = w_take ? w_cause_oh : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_overrun    <= '0;
      r_mask       <= '1;
      r_elig       <= '0;
    end else begin
      r_pending    <= (r_pending & ~w_ack_clr) | w_pulse;
      r_overrun    <= r_overrun | (w_pulse & r_pending & ~w_ack_clr);
      r_in_service <= (r_in_service & ~w_eret_clr) | w_ack_clr;
      r_elig       <= r_pending & r_mask;
      if (mask_we) begin
        r_mask <= mask_din;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_exp_req   <= 1'b0;
      r_exp_cause <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand_ok) begin
            r_state     <= ST_REQ;
            r_exp_req   <= 1'b1;
            r_exp_cause <= w_cand_pe.idx[CW-1:0];
          end
        end
        ST_REQ: begin
          if (w_take || w_abort) begin
            r_state   <= ST_IDLE;
            r_exp_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_exp_req <= 1'b0;
        end
      endcase
    end
  end

  assign exp_req    = r_exp_req;
  assign exp_cause  = r_exp_cause;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign exp_block  = |r_in_service;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed bench for exception_arbiter; expectations follow the build's
// EXCEPTION_ARBITER_NEST_EN setting.
module tb_exception_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] exp_src;
  logic       mask_we;
  logic [2:0] mask_din;
  logic       exp_ack;
  logic       eret;
  logic       exp_req;
  logic [1:0] exp_cause;
  logic [2:0] in_service;
  logic [2:0] pending;
  logic       exp_block;
  logic [2:0] overrun;

  int checks   = 0;
  int failures = 0;

  exception_arbiter #(.NSRC(3), .CW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .exp_src    (exp_src),
    .mask_we    (mask_we),
    .mask_din   (mask_din),
    .exp_ack    (exp_ack),
    .eret       (eret),
    .exp_req    (exp_req),
    .exp_cause  (exp_cause),
    .in_service (in_service),
    .pending    (pending),
    .exp_block  (exp_block),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    exp_ack = 1'b1;
    tick(1);
    exp_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  task automatic write_mask(input logic [2:0] m);
    mask_we  = 1'b1;
    mask_din = m;
    tick(1);
    mask_we  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; exp_src = '0; mask_we = 1'b0; mask_din = '0; exp_ack = 1'b0; eret = 1'b0;
    tick(2);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_in_service", 32'(in_service), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_req", 32'(exp_req), 0);
    chk("rst_cause", 32'(exp_cause), 0);
    chk("rst_block", 32'(exp_block), 0);
    reset = 1'b0;
    tick(1);

    // single source latency and handshake
    exp_src = 3'b001;
    tick(2); chk("a_pend_c2", 32'(pending), 0);
    tick(1); chk("a_pend_c3", 32'(pending), 3'b001); chk("a_req_c3", 32'(exp_req), 0);
    exp_src = '0;
    tick(1); chk("a_req_c4", 32'(exp_req), 0);
    tick(1); chk("a_req_c5", 32'(exp_req), 1); chk("a_cause_c5", 32'(exp_cause), 0);
    tick(2); chk("a_req_held", 32'(exp_req), 1);
    do_ack();
    chk("a_ack_isv", 32'(in_service), 3'b001);
    chk("a_ack_pend", 32'(pending), 0);
    chk("a_ack_req", 32'(exp_req), 0);
    chk("a_ack_block", 32'(exp_block), 1);
    tick(3); chk("a_no_rereq", 32'(exp_req), 0);
    do_eret(); chk("a_eret_isv", 32'(in_service), 0);
    do_ack(); chk("a_idle_ack_isv", 32'(in_service), 0); chk("a_idle_ack_req", 32'(exp_req), 0);

    // simultaneous src0 and src2
    exp_src = 3'b101;
    tick(3); exp_src = '0;
    tick(2);
    chk("b_req", 32'(exp_req), 1); chk("b_cause", 32'(exp_cause), 2); chk("b_pend", 32'(pending), 3'b101);
    do_ack();
    chk("b_ack_isv", 32'(in_service), 3'b100); chk("b_ack_pend", 32'(pending), 3'b001);
    tick(4); chk("b_low_blocked", 32'(exp_req), 0);
    do_eret(); chk("b_eret_isv", 32'(in_service), 0); chk("b_eret_req", 32'(exp_req), 0);
    tick(1); chk("b_req2", 32'(exp_req), 1); chk("b_cause2", 32'(exp_cause), 0);
    do_ack(); chk("b_ack2_isv", 32'(in_service), 3'b001);
    do_eret(); chk("b_eret2_isv", 32'(in_service), 0);

    // higher source arrives while src0 is in service
    exp_src = 3'b001;
    tick(3); exp_src = '0;
    tick(2); chk("c_req0", 32'(exp_cause), 0);
    do_ack(); chk("c_isv0", 32'(in_service), 3'b001);
    exp_src = 3'b100;
    tick(3); exp_src = '0;
    tick(2);
`ifdef EXCEPTION_ARBITER_NEST_EN
    chk("c_nest_req", 32'(exp_req), 1); chk("c_nest_cause", 32'(exp_cause), 2);
    do_ack(); chk("c_nest_isv", 32'(in_service), 3'b101);
    do_eret(); chk("c_unwind1", 32'(in_service), 3'b001);
    do_eret(); chk("c_unwind2", 32'(in_service), 0);
`else
    chk("c_flat_noreq", 32'(exp_req), 0); chk("c_flat_pend", 32'(pending), 3'b100);
    tick(2); chk("c_flat_noreq2", 32'(exp_req), 0);
    do_eret(); chk("c_flat_eret", 32'(in_service), 0);
    tick(1); chk("c_flat_req", 32'(exp_req), 1); chk("c_flat_cause", 32'(exp_cause), 2);
    do_ack(); chk("c_flat_isv", 32'(in_service), 3'b100);
    do_eret(); chk("c_flat_eret2", 32'(in_service), 0);
`endif

    // masking, unmask latency, abort on disable
    write_mask(3'b011);
    exp_src = 3'b100;
    tick(3); exp_src = '0;
    chk("d_pend", 32'(pending), 3'b100);
    tick(4); chk("d_masked", 32'(exp_req), 0);
    write_mask(3'b111); chk("d_unmask_c0", 32'(exp_req), 0);
    tick(1); chk("d_unmask_c1", 32'(exp_req), 0);
    tick(1); chk("d_unmask_req", 32'(exp_req), 1); chk("d_unmask_cause", 32'(exp_cause), 2);
    write_mask(3'b011);
    chk("d_abort_req", 32'(exp_req), 0); chk("d_abort_pend", 32'(pending), 3'b100);
    chk("d_abort_isv", 32'(in_service), 0);
    tick(2); chk("d_abort_stay", 32'(exp_req), 0);
    write_mask(3'b111);
    tick(2); chk("d_rereq", 32'(exp_req), 1);
    exp_ack = 1'b1; eret = 1'b1;
    tick(1);
    exp_ack = 1'b0; eret = 1'b0;
    chk("d_ack_eret_isv", 32'(in_service), 3'b100); chk("d_ack_eret_pend", 32'(pending), 0);
    do_eret(); chk("d_eret_isv", 32'(in_service), 0);

    // edge arriving in the ack cycle
    exp_src = 3'b010;
    tick(3); exp_src = '0;
    tick(2); chk("f_req", 32'(exp_req), 1); chk("f_cause", 32'(exp_cause), 1);
    exp_src = 3'b010;
    tick(1); exp_src = '0;
    tick(1);
    do_ack();
    chk("f_pend_kept", 32'(pending), 3'b010); chk("f_isv", 32'(in_service), 3'b010);
    chk("f_no_overrun", 32'(overrun), 0); chk("f_req_drop", 32'(exp_req), 0);
    tick(2); chk("f_wait", 32'(exp_req), 0);
    do_eret(); chk("f_eret", 32'(in_service), 0);
    tick(1); chk("f_req2", 32'(exp_req), 1); chk("f_cause2", 32'(exp_cause), 1);
    do_ack(); chk("f_pend2", 32'(pending), 0); chk("f_isv2", 32'(in_service), 3'b010);
    do_eret();

    // two edges before ack -> overrun
    exp_src = 3'b010;
    tick(2); exp_src = '0;
    tick(1); chk("e_pend", 32'(pending), 3'b010);
    exp_src = 3'b010;
    tick(1); exp_src = '0;
    tick(1); chk("e_req", 32'(exp_req), 1); chk("e_cause", 32'(exp_cause), 1); chk("e_ovr0", 32'(overrun), 0);
    tick(1); chk("e_ovr1", 32'(overrun), 3'b010); chk("e_pend2", 32'(pending), 3'b010);
    do_ack(); chk("e_isv", 32'(in_service), 3'b010); chk("e_pend_clr", 32'(pending), 0);
    tick(3); chk("e_single_req", 32'(exp_req), 0); chk("e_ovr_sticky", 32'(overrun), 3'b010);

    // asynchronous reset mid-handshake; src1 stays in service
    write_mask(3'b101);
    exp_src = 3'b100;
    tick(3); exp_src = '0;
    tick(2);
`ifdef EXCEPTION_ARBITER_NEST_EN
    chk("g_pre_req", 32'(exp_req), 1); chk("g_pre_cause", 32'(exp_cause), 2);
`else
    chk("g_pre_req", 32'(exp_req), 0); chk("g_pre_pend", 32'(pending), 3'b100);
`endif
    chk("g_pre_isv", 32'(in_service), 3'b010);
    #3 reset = 1'b1;
    #1;
    chk("g_rst_req", 32'(exp_req), 0); chk("g_rst_cause", 32'(exp_cause), 0);
    chk("g_rst_isv", 32'(in_service), 0); chk("g_rst_pend", 32'(pending), 0);
    chk("g_rst_ovr", 32'(overrun), 0); chk("g_rst_block", 32'(exp_block), 0);
    tick(2);
    reset = 1'b0;
    exp_src = 3'b010;
    tick(3); exp_src = '0;
    tick(2); chk("g_mask_rst_req", 32'(exp_req), 1); chk("g_mask_rst_cause", 32'(exp_cause), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
